// File: rtl/antirrebote_pkg.sv
// antirrebote_pkg
// Shared types and constants for the input debouncing stage that feeds
// the SumaProductos logic.
//   estado_t      : per-channel debouncer state (ESTABLE / VERIFICANDO)
//   cuenta_ancho  : width of the per-channel mismatch counter
//   ANCHO_DEF     : default number of input channels
//   CICLOS_DEF    : default number of consecutive mismatching cycles to accept
//   SYNC_ETAPAS_DEF : default synchroniser depth
package antirrebote_pkg;

  localparam int ANCHO_DEF       = 4;
  localparam int CICLOS_DEF      = 16;
  localparam int SYNC_ETAPAS_DEF = 2;

  typedef enum logic {
    ESTABLE     = 1'b0,
    VERIFICANDO = 1'b1
  } estado_t;

  // The counter must be able to hold the value CICLOS itself.
  function automatic int cuenta_ancho(input int ciclos);
    return $clog2(ciclos + 1);
  endfunction

endpackage

// File: rtl/antirrebote_entradas_if.sv
// antirrebote_entradas_if
// Bundles the data signals between the raw switch inputs, the debouncer and
// the downstream SumaProductos stage.
//   Crudo   : raw switch levels, asynchronous to the system clock
//   Entrada : debounced, registered word
//   Cambio  : one-cycle pulse when Entrada takes a new value
//   Subida  : per-bit rising-edge pulse of Entrada (zero unless the edge
//             detector is built in)
// The slave modport is the debouncer side; the master modport is the side
// that drives the raw inputs and consumes the conditioned word.
interface antirrebote_entradas_if
  import antirrebote_pkg::*;
#(
  parameter int ANCHO = ANCHO_DEF
);

  logic [ANCHO-1:0] Crudo;
  logic [ANCHO-1:0] Entrada;
  logic             Cambio;
  logic [ANCHO-1:0] Subida;

  modport master (
    output Crudo,
    input  Entrada,
    input  Cambio,
    input  Subida
  );

  modport slave (
    input  Crudo,
    output Entrada,
    output Cambio,
    output Subida
  );

endinterface

// File: rtl/antirrebote_canal.sv
// antirrebote_canal
// One debouncing channel: a SYNC_ETAPAS-deep synchroniser followed by a
// two-state FSM that only accepts a new level after CICLOS consecutive
// cycles of disagreement with the current debounced value.
//   clk    : system clock
//   reset  : asynchronous, active-high reset
//   crudo  : raw asynchronous input bit
//   valor  : debounced, registered bit
//   acepta : high during the cycle before the edge on which valor takes
//            a new value
module antirrebote_canal
  import antirrebote_pkg::*;
#(
  parameter int CICLOS      = CICLOS_DEF,
  parameter int SYNC_ETAPAS = SYNC_ETAPAS_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic crudo,
  output logic valor,
  output logic acepta
);

  localparam int             CW     = cuenta_ancho(CICLOS);
  localparam logic [CW-1:0]  LIMITE = CW'(CICLOS);

  logic [SYNC_ETAPAS-1:0] cadena;
  logic                   sinc;
  estado_t                estado;
  estado_t                estado_sig;
  logic [CW-1:0]          cuenta;
  logic [CW-1:0]          cuenta_sig;
  logic [CW-1:0]          cuenta_paso;
  logic                   valor_sig;

  // Synchroniser chain; the raw bit enters at index 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cadena <= '0;
    end else begin
      cadena <= {cadena[SYNC_ETAPAS-2:0], crudo};
    end
  end

  assign sinc = cadena[SYNC_ETAPAS-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado <= ESTABLE;
      cuenta <= '0;
      valor  <= 1'b0;
    end else begin
      estado <= estado_sig;
      cuenta <= cuenta_sig;
      valor  <= valor_sig;
    end
  end

  // cuenta_paso is the length of the mismatch run including this cycle.
  // From ESTABLE that run starts at 1, which also covers CICLOS = 1.
  // Any agreement between sinc and valor discards the run.
  always_comb begin
    estado_sig  = estado;
    cuenta_sig  = '0;
    valor_sig   = valor;
    acepta      = 1'b0;
    cuenta_paso = (estado == VERIFICANDO) ? cuenta + CW'(1) : CW'(1);

    if (sinc == valor) begin
      estado_sig = ESTABLE;
    end else if (cuenta_paso == LIMITE) begin
      acepta     = 1'b1;
      valor_sig  = sinc;
      estado_sig = ESTABLE;
    end else begin
      estado_sig = VERIFICANDO;
      cuenta_sig = cuenta_paso;
    end
  end

endmodule

// File: rtl/antirrebote_entradas.sv
// antirrebote_entradas
// Input conditioning stage ahead of SumaProductos: synchronises and
// debounces ANCHO raw switch inputs independently and reports changes.
//   clk   : system clock
//   reset : asynchronous, active-high reset
//   bus   : antirrebote_entradas_if slave (Crudo in; Entrada, Cambio,
//           Subida out)
// Optional feature macro: ANTIRREBOTE_FLANCOS_EN builds the per-bit
// rising-edge register behind Subida; without it Subida is tied to zero.
module antirrebote_entradas
  import antirrebote_pkg::*;
#(
  parameter int ANCHO       = ANCHO_DEF,
  parameter int CICLOS      = CICLOS_DEF,
  parameter int SYNC_ETAPAS = SYNC_ETAPAS_DEF
) (
  input logic                   clk,
  input logic                   reset,
  antirrebote_entradas_if.slave bus
);

  logic [ANCHO-1:0] entrada;
  logic [ANCHO-1:0] acepta;
  logic             cambio;

  for (genvar i = 0; i < ANCHO; i++) begin : g_canal
    antirrebote_canal #(
      .CICLOS      (CICLOS),
      .SYNC_ETAPAS (SYNC_ETAPAS)
    ) u_canal (
      .clk    (clk),
      .reset  (reset),
      .crudo  (bus.Crudo[i]),
      .valor  (entrada[i]),
      .acepta (acepta[i])
    );
  end

  // Registered alongside Entrada, so the pulse lines up with the new word;
  // simultaneous acceptances collapse into one pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cambio <= 1'b0;
    end else begin
      cambio <= |acepta;
    end
  end

  assign bus.Entrada = entrada;
  assign bus.Cambio  = cambio;

`ifdef ANTIRREBOTE_FLANCOS_EN
  logic [ANCHO-1:0] subida;

  // Accepting a channel whose current value is 0 means it goes to 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      subida <= '0;
    end else begin
      subida <= acepta & ~entrada;
    end
  end

  assign bus.Subida = subida;
`else
  assign bus.Subida = '0;
`endif

endmodule
